// File: rtl/mul_tail_pipe.sv
// Multiply-pipeline tail (M2..M5): carries the M1 result to writeback with stall/flush,
// and answers decode's RAW-hazard queries against in-flight destinations.
module mul_tail_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int STAGES = 4   // legal range 1..8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite_in,
  input  logic [ADDR_W-1:0] wreg_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic              overflow_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] query_a,
  input  logic [ADDR_W-1:0] query_b,
  output logic              regwrite_out,
  output logic [ADDR_W-1:0] wreg_out,
  output logic [DATA_W-1:0] result_out,
  output logic              zero_out,
  output logic              overflow_out,
  output logic              hit_a,
  output logic              hit_b,
  output logic [3:0]        pending
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] result;
    logic              overflow;
  } entry_t;

  entry_t stage_q [STAGES];
  entry_t entry_in;
  entry_t last_q;

  // A write to r0 travels as a bubble: data is kept, but it never writes back or hits.
  always_comb begin
    entry_in.valid    = regwrite_in && (wreg_in != '0);
    entry_in.wreg     = wreg_in;
    entry_in.result   = result_in;
    entry_in.overflow = overflow_in;
  end

  // NOTE: state uses non-blocking assignments so every stage samples the pre-edge
  // value of its predecessor; blocking here would collapse the pipeline into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stage registers are a handful of flops, not a RAM, so every field
      // is reset; this keeps the outputs and hazard queries defined out of reset.
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (flush) begin
      // Flush outranks stall; only valid bits are killed, data fields are left alone.
      for (int k = 0; k < STAGES; k++) stage_q[k].valid <= 1'b0;
    end else if (!stall) begin
      stage_q[0] <= entry_in;
      for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign last_q       = stage_q[STAGES-1];
  assign regwrite_out = last_q.valid;
  assign wreg_out     = last_q.wreg;
  assign result_out   = last_q.result;
  assign zero_out     = last_q.valid && (last_q.result == '0);
  assign overflow_out = last_q.valid && last_q.overflow;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    pending = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stage_q[k].valid && (stage_q[k].wreg == query_a) && (query_a != '0)) hit_a = 1'b1;
      if (stage_q[k].valid && (stage_q[k].wreg == query_b) && (query_b != '0)) hit_b = 1'b1;
      pending = pending + 4'(stage_q[k].valid);
    end
  end

endmodule

// File: doc/mul_tail_pipe.md
Name: mul_tail_pipe

Overview:
- Multiply-pipeline tail that sits directly downstream of the M1 multiply stage.
- Carries M1's result, destination register, write enable and overflow flag through the remaining STAGES pipeline registers (M2..M5) and presents them to writeback.
- Supports stall and flush.
- Exposes a combinational in-flight destination query so decode can detect RAW hazards against pending multiplies.

Parameters:
- DATA_W, 32, result width (REG_SIZE)
- ADDR_W, 5, register address width (REG_ADDR)
- STAGES, 4, number of tail stages (M2..M5); legal range 1..8

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- regwrite_in  input  1  M1 regwrite_out; entry is valid when 1
- wreg_in  input  ADDR_W  M1 wreg_out
- result_in  input  DATA_W  M1 m1result
- overflow_in  input  1  M1 m1overflow
- stall  input  1  hold all stages
- flush  input  1  kill all in-flight entries
- query_a  input  ADDR_W  decode source register A
- query_b  input  ADDR_W  decode source register B
- regwrite_out  output  1  writeback enable, final stage
- wreg_out  output  ADDR_W  writeback destination
- result_out  output  DATA_W  writeback data
- zero_out  output  1  result_out == 0, qualified by regwrite_out
- overflow_out  output  1  overflow flag, final stage
- hit_a  output  1  query_a matches a pending destination
- hit_b  output  1  query_b matches a pending destination
- pending  output  4  count of valid entries, 0..STAGES

Behaviour:
- Reset (rst=1, asynchronous):
  - every stage valid bit, wreg, result and overflow cleared to 0.
  - All outputs are therefore 0, including hit_a, hit_b and pending.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Entry qualification: stage-1 valid = regwrite_in && (wreg_in != 0). A write to r0 enters as a bubble: valid=0, data still captured.
- Normal cycle (stall=0, flush=0):
  - stage1 <= input;
  - stage k <= stage k-1 for k = 2..STAGES.
- Latency: an entry captured at edge N appears on the outputs after edge N+STAGES-1 (STAGES=4: 3 cycles after capture, 4 edges total from the M1 output edge). Throughput is 1 per cycle.
- Outputs: driven directly from the final stage registers, no combinational path from the inputs.
  - regwrite_out = final valid.
  - zero_out = final valid && result == 0.
  - overflow_out = final valid && overflow.
  - wreg_out and result_out show raw final-stage contents.
- Stall (stall=1, flush=0):
  - all stages hold their values; input is ignored.
  - Outputs hold, so writeback sees the same entry repeatedly. Writeback must gate its write on its own stall; that is not this block's job.
- Flush:
  - at the edge, all valid bits are cleared; data fields may be left as they are.
  - The input on that cycle is also discarded.
  - flush takes priority over stall.
- Hazard query (combinational):
  - hit_x = OR over stages k of (valid_k && wreg_k == query_x).
  - query_x == 0 never hits.
  - The input entry is not included; the caller checks M1 separately.
- pending: combinational popcount of the valid bits, zero-extended to 4 bits.
- Simultaneous events:
  - stall plus a valid input: the input is dropped (upstream is stalled too).
  - flush plus a query in the same cycle: hits reflect the pre-flush state until the edge.
- Width rule: no arithmetic on the datapath; all fields are copied bit-exact.

Test Plan:
- Reset:
  - Stimulus: 3 valid entries loaded, then rst pulsed asynchronously between edges.
  - Required: all outputs 0 within the same cycle, and pending=0.
- Latency:
  - Stimulus: STAGES=4; at edge 0 apply regwrite_in=1, wreg_in=7, result_in=0x0000_0042, overflow_in=1.
  - Required: regwrite_out=1, wreg_out=7, result_out=0x42, overflow_out=1, zero_out=0 after edge 3, and valid for exactly one cycle.
- Back-to-back with r0:
  - Stimulus: wreg 3, 0, 5 on consecutive cycles, results 0, 9, 0x10.
  - Required: outputs on consecutive cycles are (valid, r3, zero_out=1), then a bubble, then (valid, r5, 0x10). pending peaks at 2.
- Stall:
  - Stimulus: 2 entries in flight; hold stall for 3 cycles while inputs toggle.
  - Required: stage contents and outputs frozen, and inputs during the stall never appear.
- Flush beats stall:
  - Stimulus: pipeline full; assert flush=1 and stall=1 together.
  - Required: after the edge pending=0 and regwrite_out=0, and the next valid input flows normally.
- Hazard:
  - Stimulus: entries to r4 (stage 2) and r9 (stage 4); query_a=9, query_b=4, then query_a=0, query_b=11.
  - Required: hits 1/1, then 0/0. After the r9 entry exits, query_a=9 gives 0.
